// File: rtl/dylock_pkg.sv
// Shared DyLock definitions: LFSR constants, the issuer state type and the
// 4-bit nonlinear map that the checker uses on every key nibble.
package dylock_pkg;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
    // Feedback taps at bits 15, 13, 12 and 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic [3:0] nl_map(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h8;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h2;
            4'h4: y = 4'hE;  4'h5: y = 4'h1;  4'h6: y = 4'h7;  4'h7: y = 4'hC;
            4'h8: y = 4'h0;  4'h9: y = 4'hD;  4'hA: y = 4'h6;  4'hB: y = 4'h9;
            4'hC: y = 4'h3;  4'hD: y = 4'hF;  4'hE: y = 4'hA;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], ^(x & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dylock_tk_map.sv
// Combinational transformed-key map: nl_map applied independently per nibble.
module dylock_tk_map
    import dylock_pkg::*;
(
    input  logic [15:0] key_i,
    output logic [15:0] tk_o
);

    for (genvar i = 0; i < 4; i++) begin : g_nib
        assign tk_o[4*i +: 4] = nl_map(key_i[4*i +: 4]);
    end

endmodule

// File: rtl/dylock_key_issuer.sv
// Issues a burst of LFSR-generated keys with ready/valid handshake, presenting
// each key together with its registered transformed key.
module dylock_key_issuer
    import dylock_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] seed,
    input  logic [3:0]  burst_len,
    input  logic        key_ready,
    output logic [15:0] key_out,
    output logic [15:0] tk_out,
    output logic        key_valid,
    output logic        busy,
    output logic        done,
    output logic [4:0]  issued_cnt
);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] key_q, key_d;
    logic [15:0] tk_q, tk_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  len_q, len_d;
    logic        load;
    logic        xfer;
    logic [15:0] lfsr_nxt;
    logic [4:0]  cnt_inc;

    assign xfer     = (state_q == ST_ISSUE) && key_ready;
    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign cnt_inc  = cnt_q + 5'd1;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                    key_d   = lfsr_d;
                    load    = 1'b1;
                    cnt_d   = 5'd0;
                    len_d   = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (xfer) begin
                    lfsr_d = lfsr_nxt;
                    key_d  = lfsr_nxt;
                    load   = 1'b1;
                    cnt_d  = cnt_inc;
                end
                // Abort wins over completion; a coincident transfer is still counted
                if (abort)
                    state_d = ST_IDLE;
                else if (xfer && cnt_inc == len_q)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Map the next key so tk_out is registered alongside key_out
    dylock_tk_map u_tk_map (
        .key_i (key_d),
        .tk_o  (tk_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= LFSR_DEFAULT;
            key_q   <= 16'h0000;
            tk_q    <= 16'h0000;
            cnt_q   <= 5'd0;
            len_q   <= 5'd16;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            if (load)
                tk_q <= tk_d;
        end
    end

    assign key_out    = key_q;
    assign tk_out     = tk_q;
    assign issued_cnt = cnt_q;
    assign key_valid  = (state_q == ST_ISSUE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule
